// File: rtl/riscv_pipe_pkg.sv
// Shared definitions for the RISC-V pipeline stage registers.
package riscv_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake and payload bundle between two adjacent pipeline stages.
interface pipe_stage_skid_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32,
  parameter int unsigned SB_W = 1
);
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_pc4;
  logic [SB_W-1:0] in_sb;
  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc4;
  logic [SB_W-1:0] out_sb;

  modport master (
    output in_valid, in_instr, in_pc, in_pc4, in_sb, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pc4, out_sb
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_pc4, in_sb, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pc4, out_sb
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with two-entry skid buffer, flush and NOP bubbles.
// Main entry drives the outputs; in_ready and out_valid are flops.
module pipe_stage_skid #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ILEN    = 32,
  parameter int unsigned SB_W    = 1,
  parameter bit          GEN_PC4 = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall_clr,
  output logic [CNT_W-1:0] stall_cnt,
  pipe_stage_skid_if.slave bus
);
  import riscv_pipe_pkg::*;

  localparam int unsigned     PW         = ILEN + 2 * XLEN + SB_W;
  localparam logic [ILEN-1:0] NOP_BUBBLE = ILEN'(NOP_INSTR);

  stage_state_t    r_state;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [PW-1:0]   r_main;
  logic [PW-1:0]   r_skid;

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_stall;
  logic [XLEN-1:0] w_in_pc4;
  logic [PW-1:0]   w_in_pay;
  logic [ILEN-1:0] w_main_instr;

  assign w_in_fire  = bus.in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;
  assign w_stall    = r_out_valid && !bus.out_ready;

  // PC+4 is captured with the beat so the output path carries no adder.
  assign w_in_pc4 = GEN_PC4 ? (bus.in_pc + XLEN'(PC_STEP)) : bus.in_pc4;
  assign w_in_pay = {bus.in_instr, bus.in_pc, w_in_pc4, bus.in_sb};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main      <= w_in_pay;
            r_state     <= BUSY;
            r_out_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (w_in_fire && !w_out_fire) begin
            r_skid     <= w_in_pay;
            r_state    <= FULL;
            r_in_ready <= 1'b0;
          end else if (w_in_fire) begin
            r_main <= w_in_pay;
          end else if (w_out_fire) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (w_out_fire) begin
            r_main     <= r_skid;
            r_state    <= BUSY;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign {w_main_instr, bus.out_pc, bus.out_pc4, bus.out_sb} = r_main;
  assign bus.out_instr = r_out_valid ? w_main_instr : NOP_BUBBLE;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_stall),
    .clr   (stall_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: list-based reference model plus directed literal checks.
module tb_pipe_stage_skid;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        sb;
  } pay_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        stall_clr;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;
  bit          chk_on = 1'b0;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  // Reference model: an ordered list of held beats per instance (capacity 2).
  pay_t        ml[2][2];
  int unsigned mn[2]    = '{0, 0};
  pay_t        mlast[2] = '{'0, '0};
  int unsigned mst[2]   = '{0, 0};
  int unsigned smax[2]  = '{65535, 15};

  pipe_stage_skid_if #(.XLEN(32), .ILEN(32), .SB_W(1)) ia ();
  pipe_stage_skid_if #(.XLEN(32), .ILEN(32), .SB_W(1)) ib ();

  pipe_stage_skid #(.XLEN(32), .ILEN(32), .SB_W(1), .GEN_PC4(1'b1), .CNT_W(16)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stall_clr (stall_clr),
    .stall_cnt (stall_a),
    .bus       (ia.slave)
  );

  pipe_stage_skid #(.XLEN(32), .ILEN(32), .SB_W(1), .GEN_PC4(1'b0), .CNT_W(4)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .stall_clr (stall_clr),
    .stall_cnt (stall_b),
    .bus       (ib.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, k, $time, act, exp);
    end
  endtask

  task automatic mstep(input int k, input logic iv, input logic ordy, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [31:0] pc4in, input logic sb);
    bit   fin, fout;
    pay_t p;
    fin  = iv && (mn[k] < 2);
    fout = (mn[k] > 0) && ordy;
    if (stall_clr) mst[k] = 0;
    else if ((mn[k] > 0) && !ordy && (mst[k] < smax[k])) mst[k]++;
    p.instr = instr;
    p.pc    = pc;
    p.pc4   = (k == 0) ? pc + 32'd4 : pc4in;
    p.sb    = sb;
    if (flush) begin
      mn[k] = 0;
    end else begin
      if (fout) begin
        ml[k][0] = ml[k][1];
        mn[k]--;
      end
      if (fin) begin
        ml[k][mn[k]] = p;
        mn[k]++;
      end
    end
    if (mn[k] > 0) mlast[k] = ml[k][0];
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        mn[k] = 0; mlast[k] = '0; mst[k] = 0;
      end
    end else begin
      mstep(0, ia.in_valid, ia.out_ready, ia.in_instr, ia.in_pc, ia.in_pc4, ia.in_sb);
      mstep(1, ib.in_valid, ib.out_ready, ib.in_instr, ib.in_pc, ib.in_pc4, ib.in_sb);
    end
  end

  task automatic cmp(input int k, input logic rdy, input logic ov, input logic [31:0] instr,
                     input logic [31:0] pc, input logic [31:0] pc4, input logic sb,
                     input logic [31:0] st);
    chk("in_ready",  k, {31'b0, rdy}, {31'b0, mn[k] < 2});
    chk("out_valid", k, {31'b0, ov},  {31'b0, mn[k] > 0});
    chk("out_instr", k, instr, (mn[k] > 0) ? mlast[k].instr : 32'h0000_0013);
    chk("out_pc",    k, pc,  mlast[k].pc);
    chk("out_pc4",   k, pc4, mlast[k].pc4);
    chk("out_sb",    k, {31'b0, sb}, {31'b0, mlast[k].sb});
    chk("stall_cnt", k, st, mst[k]);
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      cmp(0, ia.in_ready, ia.out_valid, ia.out_instr, ia.out_pc, ia.out_pc4, ia.out_sb, {16'b0, stall_a});
      cmp(1, ib.in_ready, ib.out_valid, ib.out_instr, ib.out_pc, ib.out_pc4, ib.out_sb, {28'b0, stall_b});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic seta(input logic v, input logic [31:0] instr, input logic [31:0] pc, input logic ordy);
    ia.in_valid  = v;
    ia.in_instr  = instr;
    ia.in_pc     = pc;
    ia.in_pc4    = ~pc;
    ia.in_sb     = pc[2];
    ia.out_ready = ordy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pat_v;
    logic [15:0] pat_r;
    logic [31:0] pc;
    bit          acc;

    reset = 1'b1; flush = 1'b0; stall_clr = 1'b0;
    seta(1'b0, '0, '0, 1'b0);
    ib.in_valid = 1'b0; ib.in_instr = '0; ib.in_pc = '0; ib.in_pc4 = '0; ib.in_sb = 1'b0;
    ib.out_ready = 1'b0;
    cyc(); cyc();
    chk("rst_in_ready", 0, {31'b0, ia.in_ready}, 32'd1);
    chk("rst_out_valid", 0, {31'b0, ia.out_valid}, 32'd0);
    chk("rst_out_instr", 0, ia.out_instr, 32'h0000_0013);
    chk("rst_out_pc", 0, ia.out_pc, 32'd0);
    chk("rst_stall", 0, {16'b0, stall_a}, 32'd0);
    reset = 1'b0; chk_on = 1'b1;
    cyc();

    // Single beat
    seta(1'b1, 32'h0050_0093, 32'h100, 1'b1); cyc();
    seta(1'b0, '0, '0, 1'b1);
    chk("single_valid", 0, {31'b0, ia.out_valid}, 32'd1);
    chk("single_pc4", 0, ia.out_pc4, 32'h104);
    chk("single_instr", 0, ia.out_instr, 32'h0050_0093);
    cyc();
    chk("bubble_valid", 0, {31'b0, ia.out_valid}, 32'd0);
    chk("bubble_instr", 0, ia.out_instr, 32'h0000_0013);
    chk("bubble_pc_hold", 0, ia.out_pc, 32'h100);

    // Back-pressure: three beats offered, two held
    seta(1'b1, 32'h0000_0093, 32'h0, 1'b0); cyc();
    chk("bp_ready1", 0, {31'b0, ia.in_ready}, 32'd1);
    seta(1'b1, 32'h0010_0093, 32'h4, 1'b0); cyc();
    chk("bp_ready2", 0, {31'b0, ia.in_ready}, 32'd0);
    seta(1'b1, 32'h0020_0093, 32'h8, 1'b0); cyc(); cyc();
    chk("bp_ready_held", 0, {31'b0, ia.in_ready}, 32'd0);
    chk("bp_head", 0, ia.out_pc, 32'h0);
    chk("bp_stall", 0, {16'b0, stall_a}, 32'd3);
    ia.out_ready = 1'b1; cyc();
    chk("bp_second", 0, ia.out_pc, 32'h4);
    chk("bp_ready_back", 0, {31'b0, ia.in_ready}, 32'd1);
    cyc();
    chk("bp_third", 0, ia.out_pc, 32'h8);
    seta(1'b0, '0, '0, 1'b1); cyc();
    chk("bp_drained", 0, {31'b0, ia.out_valid}, 32'd0);

    // Flush in FULL with a beat offered
    seta(1'b1, 32'h13, 32'h200, 1'b0); cyc();
    seta(1'b1, 32'h13, 32'h204, 1'b0); cyc();
    seta(1'b1, 32'h13, 32'h208, 1'b0); flush = 1'b1; cyc();
    flush = 1'b0; seta(1'b0, '0, '0, 1'b0);
    chk("flush_valid", 0, {31'b0, ia.out_valid}, 32'd0);
    chk("flush_ready", 0, {31'b0, ia.in_ready}, 32'd1);
    chk("flush_keeps_stall", 0, {16'b0, stall_a}, 32'd5);
    cyc(); cyc();
    chk("flush_stays_empty", 0, {31'b0, ia.out_valid}, 32'd0);

    // Flush in BUSY: head delivered, incoming beat discarded
    seta(1'b1, 32'h13, 32'h300, 1'b1); cyc();
    seta(1'b1, 32'h13, 32'h304, 1'b1); flush = 1'b1; cyc();
    flush = 1'b0; seta(1'b0, '0, '0, 1'b1);
    chk("flush_busy_valid", 0, {31'b0, ia.out_valid}, 32'd0);
    chk("flush_busy_pc", 0, ia.out_pc, 32'h300);
    cyc();

    // stall_clr beats a simultaneous stall increment
    seta(1'b1, 32'h13, 32'h400, 1'b0); cyc();
    seta(1'b0, '0, '0, 1'b0); stall_clr = 1'b1; cyc();
    stall_clr = 1'b0;
    chk("clr_wins", 0, {16'b0, stall_a}, 32'd0);
    cyc();
    chk("clr_then_count", 0, {16'b0, stall_a}, 32'd1);
    ia.out_ready = 1'b1; cyc();

    // PC+4 wrap
    seta(1'b1, 32'h13, 32'hFFFF_FFFC, 1'b1); cyc();
    seta(1'b0, '0, '0, 1'b1);
    chk("wrap_pc4", 0, ia.out_pc4, 32'h0);
    chk("wrap_pc", 0, ia.out_pc, 32'hFFFF_FFFC);
    cyc();

    // Sustained throughput
    for (int i = 0; i < 6; i++) begin
      seta(1'b1, 32'h13 | (i << 7), 32'h600 + 32'(4 * i), 1'b1); cyc();
      chk("tput_ready", 0, {31'b0, ia.in_ready}, 32'd1);
      chk("tput_pc", 0, ia.out_pc, 32'h600 + 32'(4 * i));
    end
    seta(1'b0, '0, '0, 1'b1); cyc();

    // Mixed valid/ready pattern, ordering checked by the model
    pat_v = 16'b1011_1110_0111_1111;
    pat_r = 16'b1100_1010_0011_0101;
    pc = 32'h700;
    for (int i = 0; i < 16; i++) begin
      seta(pat_v[i], 32'h93 | (pc << 12), pc, pat_r[i]);
      acc = ia.in_valid && ia.in_ready;
      cyc();
      if (acc) pc = pc + 32'd4;
    end
    seta(1'b0, '0, '0, 1'b1); cyc(); cyc(); cyc();

    // Asynchronous reset mid-burst in BUSY
    seta(1'b1, 32'h13, 32'h500, 1'b0); cyc();
    seta(1'b1, 32'h13, 32'h504, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 0, {31'b0, ia.out_valid}, 32'd0);
    chk("arst_ready", 0, {31'b0, ia.in_ready}, 32'd1);
    chk("arst_instr", 0, ia.out_instr, 32'h0000_0013);
    chk("arst_pc", 0, ia.out_pc, 32'h0);
    chk("arst_pc4", 0, ia.out_pc4, 32'h0);
    chk("arst_stall", 0, {16'b0, stall_a}, 32'd0);
    cyc();
    seta(1'b0, '0, '0, 1'b0);
    reset = 1'b0;
    cyc();

    // Instance B: pass-through PC+4 and 4-bit saturating counter
    ib.in_valid = 1'b1; ib.in_instr = 32'h13; ib.in_pc = 32'h40; ib.in_pc4 = 32'hDEAD;
    ib.in_sb = 1'b1; ib.out_ready = 1'b1;
    cyc();
    ib.in_valid = 1'b0; ib.out_ready = 1'b0;
    chk("b_pc4_pass", 1, ib.out_pc4, 32'hDEAD);
    chk("b_valid", 1, {31'b0, ib.out_valid}, 32'd1);
    repeat (20) cyc();
    chk("b_saturate", 1, {28'b0, stall_b}, 32'd15);
    stall_clr = 1'b1; cyc();
    stall_clr = 1'b0;
    chk("b_clr", 1, {28'b0, stall_b}, 32'd0);
    ib.out_ready = 1'b1; cyc(); cyc();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised inter-stage pipeline register for the RISC-V five-stage pipeline. It generalises the fixed IF/ID latch and carries instruction, PC, PC+4 and a sideband field. It adds a valid/ready handshake, a two-entry skid buffer so that `in_ready` is registered, synchronous flush for branch and jump redirects, and NOP bubble insertion. A saturating back-pressure counter supports performance analysis. One instance is placed between each pair of adjacent stages (IF/ID, ID/EX, …).

## Interface
- `XLEN`, default 32: PC width.
- `ILEN`, default 32: instruction width.
- `SB_W`, default 1: sideband width, e.g. predicted-taken bit; must be ≥1.
- `GEN_PC4`, default 1: when 1, `out_pc4` is computed internally as `in_pc + 4` and `in_pc4` is ignored; when 0, `in_pc4` is passed through.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous kill of all held and incoming beats.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  stage can accept a beat; driven directly by a flop.
- `in_instr`  in  ILEN  instruction.
- `in_pc`  in  XLEN  PC.
- `in_pc4`  in  XLEN  PC+4, used only when GEN_PC4=0.
- `in_sb`  in  SB_W  sideband.
- `out_valid`  out  1  downstream beat valid.
- `out_ready`  in  1  downstream accepts.
- `out_instr`, `out_pc`, `out_pc4`, `out_sb`  out  ILEN/XLEN/XLEN/SB_W  payload.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `out_valid && !out_ready`.
- `stall_clr`  in  1  synchronous clear of `stall_cnt`.

## Operation
- Fire definitions:
  - `in_fire = in_valid && in_ready`
  - `out_fire = out_valid && out_ready`
- The block holds a main register, which drives the outputs, and one skid register.
- State machine, with states EMPTY, BUSY (main full) and FULL (main and skid full):
  - EMPTY: on `in_fire`, load main and go to BUSY.
  - BUSY:
    - `in_fire && !out_fire`: load skid, go to FULL.
    - `in_fire && out_fire`: load main from input, stay in BUSY.
    - `!in_fire && out_fire`: go to EMPTY.
    - Otherwise hold.
  - FULL: `in_ready=0`. On `out_fire`, main takes skid contents and the state goes to BUSY; otherwise hold.
- Next-cycle `in_ready` equals 1 exactly when the next state is not FULL.
- Flush has the highest priority:
  - The next state is EMPTY regardless of fire signals.
  - A beat accepted in the flush cycle is discarded.
  - `out_fire` in the flush cycle still counts as delivered.
- Bubble payload: whenever `out_valid=0`, `out_instr` drives `NOP_INSTR` (32'h0000_0013, zero-extended or truncated to ILEN).
  - `out_pc`, `out_pc4` and `out_sb` hold their last values.
- PC+4 arithmetic (GEN_PC4=1): computed as `in_pc + 4` modulo 2^XLEN when the beat is captured. The value is stored, not recomputed at the output.
- `stall_cnt` increments each cycle `out_valid && !out_ready` holds and saturates at 2^CNT_W−1.
  - `stall_clr` wins over an increment in the same cycle.
  - Flush does not clear the counter.

## Timing
- Reset values: state EMPTY, `in_ready=1`, `out_valid=0`, `out_instr=NOP_INSTR`, `out_pc=0`, `out_pc4=0`, `out_sb=0`, `stall_cnt=0`.
- Latency: 1 cycle from `in_fire` to `out_valid` when the block is EMPTY, or BUSY with `out_fire`.
- Throughput: 1 beat per cycle sustained while `out_ready=1`.
- Capacity is 2 beats. `in_ready` deasserts the cycle after the skid loads and reasserts the cycle after the skid drains.
- Ordering is strict FIFO. No beat is dropped except under flush, and no beat is duplicated.
- Reset asserted mid-operation: all content is lost immediately, whatever the state.

## Structure
- Shared package `riscv_pipe_pkg` holds:
  - `NOP_INSTR` constant.
  - `stage_state_t` enum {EMPTY, BUSY, FULL}.
  - `PC_STEP` constant (4).
- Sub-module `sat_counter` (parameter W; inputs `inc`, `clr`; output `cnt`) implements `stall_cnt` and is reusable by other performance counters.
- Payload registers are packed as one concatenated vector per entry.

## Test plan
- Single beat: instr 0x00500093, pc 0x100 into EMPTY, `out_ready=1` → next cycle `out_valid=1`, `out_pc4=0x104`; the following cycle `out_valid=0` and `out_instr=0x00000013`.
- Back-pressure: 3 beats (pc 0x0, 0x4, 0x8) offered with `out_ready=0` → 2 accepted, `in_ready=0` from cycle 2, `stall_cnt` counting. Then raise `out_ready` → 0x0, 0x4, 0x8 delivered in order.
- Flush in FULL while a beat is offered → next cycle `out_valid=0`, `in_ready=1`, no flushed PC ever appears on the output.
- Wrap: pc 0xFFFFFFFC with GEN_PC4=1 → `out_pc4=0x00000000`. GEN_PC4=0 with `in_pc4=0xDEAD` → `out_pc4=0xDEAD`.
- Counter: CNT_W=4 with 20 stall cycles → `stall_cnt=15`. `stall_clr` asserted together with a stall cycle → 0.
- Async reset pulse mid-burst in BUSY → outputs immediately take reset values, with no clock edge required.
